dm_store_buffer: RTL and testbench
==================================

// Module: dm_store_buffer
// PURPOSE
//  Word-store FIFO between the MEM stage and the data memory. A sw retires into
//  the buffer in one cycle; the buffer drains one entry per cycle into dm's write port.
//  Loads see the youngest matching buffered store, so they never read a stale dm word.
//  Each drained entry carries its pc to dm, so the dm write log shows the original store.
// PARAMETERS
//  DEPTH     4   entries; power of two, >=2
//  AW        12  word-index width compared/forwarded (addr[AW+1:2])
// PORTS
//  clk       in   1   clock, rising edge
//  rst       in   1   synchronous, active-high reset
//  st_valid  in   1   MEM stage issues a word store this cycle
//  st_pc     in   32  pc of the store
//  st_addr   in   32  byte address of the store (bits [1:0] ignored)
//  st_data   in   32  store data
//  st_ready  out  1   buffer accepts st_valid this cycle; MEM stalls when 0
//  ld_valid  in   1   MEM stage issues a word load this cycle
//  ld_addr   in   32  byte address of the load
//  dm_rd     in   32  dm combinational read data at ld_addr
//  ld_data   out  32  load result (forwarded or dm_rd)
//  ld_hit    out  1   ld_data came from the buffer
//  drain_en  in   1   permits draining; 0 holds the head entry
//  dm_we     out  1   write strobe to dm (DMWr)
//  dm_pc     out  32  pc of the head entry
//  dm_addr   out  32  address of the head entry, {addr[31:2],2'b00}
//  dm_wd     out  32  data of the head entry
//  count     out  $clog2(DEPTH)+1  occupied entries
//  empty     out  1   count==0
//  full      out  1   count==DEPTH
// BEHAVIOUR
//  - State: circular array of {pc,addr,data}, head ptr, tail ptr, count. All registered.
//  - Reset (rst=1 at posedge): head=tail=0, count=0. Entry contents are don't-care.
//    Pending stores are discarded, including during a drain. After reset:
//    empty=1, full=0, st_ready=1, dm_we=0, ld_hit=0.
//  - st_ready = !full. No same-cycle pass-through when full, even while draining.
//  - Push: st_valid&&st_ready -> entry[tail]<={st_pc,st_addr,st_data}; tail++ mod DEPTH.
//    st_valid while full is ignored; the stage must hold the store.
//  - Drain: dm_we = !empty && drain_en. dm_pc/addr/wd driven from entry[head]
//    (combinational from registers). On a posedge with dm_we=1: head++, count--.
//  - Simultaneous push+drain: count unchanged; both pointers advance.
//  - Latency: a store pushed at edge N is at the head earliest for cycle N+1. It
//    reaches dm at edge N+1 if the buffer was empty and drain_en=1.
//  - Forwarding: compare ld_addr[AW+1:2] against all valid entries present at cycle start.
//    If any match: ld_hit=1, ld_data = data of the youngest match (closest to tail).
//    Else ld_hit=0, ld_data=dm_rd. An entry draining this cycle still forwards.
//    ld_valid=0 forces ld_hit=0 and ld_data=dm_rd.
//    A store pushed this cycle is not visible to a load in the same cycle.
//    The MEM stage never asserts st_valid and ld_valid together.
//  - Wrap-around: pointers wrap modulo DEPTH. Youngest-match ordering stays correct across the wrap.
// CONFIGURATION
//  DMSB_COALESCE_EN defined: a push whose word index equals the youngest entry's
//    overwrites that entry's data and pc in place. tail and count are unchanged.
//    - Applies only if that entry is not the head being drained this cycle.
//    - Coalescing is allowed while full; st_ready = !full || coalesce_match.
//  DMSB_COALESCE_EN undefined: every accepted store allocates a new entry.
// TESTING
//  T1 reset: rst=1 with 3 entries queued -> next cycle count=0, empty=1, dm_we=0, st_ready=1.
//  T2 basic: push sw 0x10<=0xAAAA5555 (pc 0x3000), drain_en=1 -> next cycle dm_we=1,
//     dm_addr=0x10, dm_wd=0xAAAA5555, dm_pc=0x3000; empty next.
//  T3 full: drain_en=0, push 0x0,0x4,0x8,0xC -> full=1, st_ready=0.
//     5th push is held; after drain_en=1 it is accepted one cycle later.
//  T4 forward: drain_en=0, push 0x20<=1 then 0x20<=2; load 0x20 with dm_rd=0 -> ld_hit=1,
//     ld_data=2. Load 0x24 -> ld_hit=0, ld_data=dm_rd.
//  T5 wrap: 10 push/drain pairs at DEPTH=4 with interleaved loads -> dm writes appear in
//     program order and every load returns the latest value.
//  T6 coalesce (macro on): drain_en=0, push 0x40<=7 then 0x40<=9 -> count=1, drains 9 once.
//     Macro off: count=2, writes 7 then 9.

Source files
------------

// File: rtl/dm_store_buffer_if.sv
// Store-buffer bus: MEM-stage store/load side plus the dm write port and status.
// The master modport is the MEM stage / dm side, the slave modport is the buffer.
interface dm_store_buffer_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          st_valid;
    logic [31:0]   st_pc;
    logic [31:0]   st_addr;
    logic [31:0]   st_data;
    logic          st_ready;

    logic          ld_valid;
    logic [31:0]   ld_addr;
    logic [31:0]   dm_rd;
    logic [31:0]   ld_data;
    logic          ld_hit;

    logic          drain_en;
    logic          dm_we;
    logic [31:0]   dm_pc;
    logic [31:0]   dm_addr;
    logic [31:0]   dm_wd;

    logic [CW-1:0] count;
    logic          empty;
    logic          full;

    modport master (
        output st_valid, st_pc, st_addr, st_data,
        output ld_valid, ld_addr, dm_rd,
        output drain_en,
        input  st_ready, ld_data, ld_hit,
        input  dm_we, dm_pc, dm_addr, dm_wd,
        input  count, empty, full
    );

    modport slave (
        input  st_valid, st_pc, st_addr, st_data,
        input  ld_valid, ld_addr, dm_rd,
        input  drain_en,
        output st_ready, ld_data, ld_hit,
        output dm_we, dm_pc, dm_addr, dm_wd,
        output count, empty, full
    );
endinterface

// File: rtl/dm_store_buffer.sv
// Word-store FIFO between MEM and data memory with youngest-match load forwarding.
// Optional: define DMSB_COALESCE_EN to merge a store into the youngest same-word entry.
module dm_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 12
) (
    input logic              clk,
    input logic              rst,
    dm_store_buffer_if.slave sb
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic [31:0] pc_q   [DEPTH];
    logic [31:2] addr_q [DEPTH];
    logic [31:0] data_q [DEPTH];

    logic [PW-1:0] head_q;
    logic [PW-1:0] head_d;
    logic [PW-1:0] tail_q;
    logic [PW-1:0] tail_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    logic          empty;
    logic          full;
    logic          drain;
    logic          push;
    logic          coal;
    logic          fwd_hit;
    logic [31:0]   fwd_data;
    logic [PW-1:0] idx;
    logic          unused_addr_bits;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);
    assign drain = !empty && sb.drain_en;

`ifdef DMSB_COALESCE_EN
    logic [PW-1:0] young;

    assign young = tail_q - PTR_ONE;
    // The head leaving this cycle cannot absorb a new store.
    assign coal  = sb.st_valid && !empty
                && addr_q[young][AW+1:2] == sb.st_addr[AW+1:2]
                && !(drain && young == head_q);
`else
    assign coal  = 1'b0;
`endif

    assign push = sb.st_valid && !full && !coal;

    always_comb begin
        head_d  = drain ? head_q + PTR_ONE : head_q;
        tail_d  = push ? tail_q + PTR_ONE : tail_q;
        count_d = count_q;
        unique case ({push, drain})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[tail_q]   <= sb.st_pc;
            addr_q[tail_q] <= sb.st_addr[31:2];
            data_q[tail_q] <= sb.st_data;
        end
`ifdef DMSB_COALESCE_EN
        if (coal) begin
            pc_q[young]   <= sb.st_pc;
            data_q[young] <= sb.st_data;
        end
`endif
    end

    // Walk oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = sb.dm_rd;
        idx      = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (sb.ld_valid && i < int'(count_q)
                && addr_q[idx][AW+1:2] == sb.ld_addr[AW+1:2]) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[idx];
            end
        end
    end

    assign sb.ld_hit   = fwd_hit;
    assign sb.ld_data  = fwd_data;

    assign sb.st_ready = !full || coal;
    assign sb.dm_we    = drain;
    assign sb.dm_pc    = pc_q[head_q];
    assign sb.dm_addr  = {addr_q[head_q], 2'b00};
    assign sb.dm_wd    = data_q[head_q];

    assign sb.count    = count_q;
    assign sb.empty    = empty;
    assign sb.full     = full;

    assign unused_addr_bits = ^{sb.st_addr[1:0], sb.ld_addr[1:0],
                                sb.ld_addr[31:AW+2]};
endmodule

// File: tb/tb_dm_store_buffer.sv
// Scoreboard bench for dm_store_buffer: queue-based buffer model plus a
// program-order shadow memory predict every cycle's status, load and dm write.
module tb_dm_store_buffer;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } ent_t;

    typedef struct packed {
        logic [CW-1:0] count;
        logic          empty;
        logic          full;
        logic          st_ready;
        logic          dm_we;
        logic          ld_hit;
        logic [31:0]   ld_data;
    } stat_t;

    logic clk;
    logic rst;

    dm_store_buffer_if #(.DEPTH(DEPTH)) sb ();

    dm_store_buffer #(.DEPTH(DEPTH), .AW(12)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    ent_t        mq[$];
    ent_t        wq[$];
    stat_t       st_q[$];
    logic [31:0] mem    [64];
    logic [31:0] shadow [64];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        stat_t s;
        ent_t  w;
        if (!rst && st_q.size() > 0) begin
            s = st_q.pop_front();
            chk("count",    32'(sb.count), 32'(s.count));
            chk("empty",    32'(sb.empty), 32'(s.empty));
            chk("full",     32'(sb.full), 32'(s.full));
            chk("st_ready", 32'(sb.st_ready), 32'(s.st_ready));
            chk("dm_we",    32'(sb.dm_we), 32'(s.dm_we));
            chk("ld_hit",   32'(sb.ld_hit), 32'(s.ld_hit));
            chk("ld_data",  sb.ld_data, s.ld_data);
            if (sb.dm_we) begin
                if (wq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL dm_write: unexpected write addr %h, none due",
                             sb.dm_addr);
                end else begin
                    w = wq.pop_front();
                    chk("dm_pc",   sb.dm_pc, w.pc);
                    chk("dm_addr", sb.dm_addr, w.addr);
                    chk("dm_wd",   sb.dm_wd, w.data);
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst         = 1'b1;
        sb.st_valid = 1'b0;
        sb.ld_valid = 1'b0;
        sb.drain_en = 1'b1;
        mq.delete();
        for (int i = 0; i < 64; i++) shadow[i] = mem[i];
    endtask

    task automatic drive(input logic sv, input logic [31:0] spc,
                         input logic [31:0] sa, input logic [31:0] sd,
                         input logic lv, input logic [31:0] la,
                         input logic den, output logic acc);
        stat_t s;
        ent_t  e;
        logic  coal;
        logic  drn;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        coal = 1'b0;
`ifdef DMSB_COALESCE_EN
        if (sv && mq.size() > 0 && mq[mq.size()-1].addr[13:2] == sa[13:2]
            && !(den && mq.size() == 1))
            coal = 1'b1;
`endif
        acc = sv && (mq.size() < DEPTH || coal);
        drn = den && mq.size() > 0;

        sb.st_valid = sv;
        sb.st_pc    = spc;
        sb.st_addr  = sa;
        sb.st_data  = sd;
        sb.ld_valid = lv;
        sb.ld_addr  = la;
        sb.dm_rd    = mem[la[7:2]];
        sb.drain_en = den;

        s.count    = CW'(mq.size());
        s.empty    = mq.size() == 0;
        s.full     = mq.size() == DEPTH;
        s.st_ready = mq.size() < DEPTH || coal;
        s.dm_we    = drn;
        s.ld_hit   = 1'b0;
        s.ld_data  = mem[la[7:2]];
        if (lv) begin
            foreach (mq[i])
                if (mq[i].addr[13:2] == la[13:2]) s.ld_hit = 1'b1;
            s.ld_data = shadow[la[7:2]];
        end
        st_q.push_back(s);

        if (coal) begin
            e      = mq.pop_back();
            e.pc   = spc;
            e.data = sd;
            mq.push_back(e);
        end
        if (drn) begin
            e = mq.pop_front();
            mem[e.addr[7:2]] = e.data;
            e.addr = {e.addr[31:2], 2'b00};
            wq.push_back(e);
        end
        if (acc && !coal) begin
            e.pc   = spc;
            e.addr = sa;
            e.data = sd;
            mq.push_back(e);
        end
        if (acc) shadow[sa[7:2]] = sd;
    endtask

    task automatic st(input logic [31:0] spc, input logic [31:0] sa,
                      input logic [31:0] sd, input logic den,
                      output logic acc);
        drive(1'b1, spc, sa, sd, 1'b0, 32'h0, den, acc);
    endtask

    task automatic ld(input logic [31:0] la, input logic den);
        logic acc;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, la, den, acc);
    endtask

    task automatic drain_all();
        for (int i = 0; i < 2 * DEPTH && mq.size() > 0; i++) ld(32'h0, 1'b1);
        ld(32'h0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acc;
        logic        pend;
        logic [31:0] ppc;
        logic [31:0] pa;
        logic [31:0] pd;
        int          r;
        logic        den;

        rst         = 1'b1;
        sb.st_valid = 1'b0;
        sb.st_pc    = '0;
        sb.st_addr  = '0;
        sb.st_data  = '0;
        sb.ld_valid = 1'b0;
        sb.ld_addr  = '0;
        sb.dm_rd    = '0;
        sb.drain_en = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[8] = 32'h0;
        do_reset();
        do_reset();

        // reset discards queued stores
        for (int i = 0; i < 3; i++)
            st(32'h2000 + 32'(i * 4), 32'h100 + 32'(i * 4), 32'h11 * 32'(i + 1), 1'b0, acc);
        do_reset();
        ld(32'h104, 1'b0);
        ld(32'h20, 1'b1);

        // basic store then drain
        st(32'h3000, 32'h10, 32'hAAAA5555, 1'b1, acc);
        ld(32'h10, 1'b1);
        ld(32'h10, 1'b1);

        // fill, hold the fifth store, release
        for (int i = 0; i < 4; i++)
            st(32'h3100 + 32'(i * 4), 32'(i * 4), 32'hC0 + 32'(i), 1'b0, acc);
        st(32'h3110, 32'h14, 32'hC4, 1'b0, acc);
        st(32'h3110, 32'h14, 32'hC4, 1'b1, acc);
        st(32'h3110, 32'h14, 32'hC4, 1'b1, acc);
        drain_all();

        // forwarding youngest match
        st(32'h3200, 32'h20, 32'h1, 1'b0, acc);
        st(32'h3204, 32'h20, 32'h2, 1'b0, acc);
        ld(32'h20, 1'b0);
        ld(32'h24, 1'b0);
        drain_all();

        // same-word pair: merged or two writes depending on build
        st(32'h3300, 32'h40, 32'h7, 1'b0, acc);
        st(32'h3304, 32'h40, 32'h9, 1'b0, acc);
        ld(32'h40, 1'b0);
        drain_all();

        // push/drain pairs across the pointer wrap
        for (int k = 0; k < 10; k++) begin
            st(32'h3400 + 32'(k * 4), 32'((k % 3) * 4 + 16'h30), 32'h500 + 32'(k), 1'b1, acc);
            ld(32'((k % 3) * 4 + 16'h30), 1'b1);
        end
        drain_all();

        pend = 1'b0;
        ppc  = '0;
        pa   = '0;
        pd   = '0;
        for (int c = 0; c < 600; c++) begin
            r   = $urandom_range(0, 9);
            den = ($urandom_range(0, 9) < 5);
            if (c == 300) begin
                do_reset();
                pend = 1'b0;
            end
            if (!pend && r < 5) begin
                pend = 1'b1;
                pa   = 32'($urandom_range(0, 11)) * 4 + 32'($urandom_range(0, 3));
                pd   = $urandom;
                ppc  = 32'h4000 + 32'(c * 4);
            end
            if (pend) begin
                st(ppc, pa, pd, den, acc);
                if (acc) pend = 1'b0;
            end else if (r < 8) begin
                ld(32'($urandom_range(0, 11)) * 4 + 32'($urandom_range(0, 3)), den);
            end else begin
                drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, den, acc);
            end
        end
        drain_all();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, acc);
        @(negedge clk);
        #1;
        chk("writes_left", 32'(wq.size()), 32'h0);
        chk("status_left", 32'(st_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
